// File: rtl/mod3719_pkg.sv
// Shared constants for the q=3719 multiply-accumulate front end.
// FOLD is the residue of 2^K modulo Q, so x[hi]*2^K + x[lo] == x[hi]*FOLD + x[lo] (mod Q).
package mod3719_pkg;

    localparam int Q      = 3719;
    localparam int K      = 12;
    localparam int FOLD   = (1 << K) - Q;

    localparam int RES_W  = 12;
    localparam int PROD_W = 24;
    localparam int FOLD_W = 21;
    localparam int ACC_W  = 22;
    localparam int OUT_W  = 23;

endpackage

// File: rtl/mod3719_fold.sv
// Combinational partial reduction: y = x[23:12]*FOLD + x[11:0].
// For any 24-bit input the result stays below 2^21, and it is congruent to x mod Q.
module mod3719_fold
    import mod3719_pkg::*;
(
    input  logic [PROD_W-1:0] x_i,
    output logic [FOLD_W-1:0] y_o
);

    localparam logic [FOLD_W-1:0] FOLD_C = FOLD_W'(FOLD);

    logic [FOLD_W-1:0] hi_scaled;

    assign hi_scaled = FOLD_W'(x_i[PROD_W-1:K]) * FOLD_C;
    assign y_o       = hi_scaled + FOLD_W'(x_i[K-1:0]);

endmodule

// File: rtl/mod3719_mac_feeder.sv
// Streaming modular multiply-accumulate front end feeding the Barrett reducer.
// Three stages (multiply, fold, accumulate) under one global stall; one 23-bit
// result per frame, congruent to sum(a*b) mod Q and kept below 2^22.
module mod3719_mac_feeder
    import mod3719_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [RES_W-1:0] s_a,
    input  logic [RES_W-1:0] s_b,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data
);

    logic              en;

    logic [PROD_W-1:0] p1_q;
    logic [PROD_W-1:0] p1_d;
    logic              v1_q;
    logic              l1_q;

    logic [FOLD_W-1:0] p2_q;
    logic [FOLD_W-1:0] p2_d;
    logic              v2_q;
    logic              l2_q;

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [FOLD_W-1:0] acc_fold;
    logic [ACC_W-1:0]  sum;

    logic [OUT_W-1:0]  m_data_q;
    logic [OUT_W-1:0]  m_data_d;
    logic              m_valid_q;
    logic              m_valid_d;

    // The whole pipe advances only when the output register is free or being drained.
    assign en      = !m_valid_q || m_ready;
    assign s_ready = en;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

    assign p1_d = PROD_W'(s_a) * PROD_W'(s_b);

    mod3719_fold u_fold_prod (
        .x_i (p1_q),
        .y_o (p2_d)
    );

    // Folding the accumulator before the add keeps it below 2^22 for any frame length.
    mod3719_fold u_fold_acc (
        .x_i (PROD_W'(acc_q)),
        .y_o (acc_fold)
    );

    assign sum = ACC_W'(acc_fold) + ACC_W'(p2_q);

    // Accumulate stage and output register next-state: close a frame on its last beat.
    always_comb begin
        acc_d     = acc_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        if (en && v2_q) begin
            if (l2_q) begin
                m_data_d  = OUT_W'(sum);
                m_valid_d = 1'b1;
                acc_d     = '0;
            end else begin
                acc_d     = sum;
            end
        end
    end

    // Pipeline, accumulator and output registers; reset wins over the stall enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_q      <= '0;
            v1_q      <= 1'b0;
            l1_q      <= 1'b0;
            p2_q      <= '0;
            v2_q      <= 1'b0;
            l2_q      <= 1'b0;
            acc_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            if (en) begin
                p1_q <= p1_d;
                v1_q <= s_valid;
                l1_q <= s_last;
                p2_q <= p2_d;
                v2_q <= v1_q;
                l2_q <= l1_q;
            end
            acc_q     <= acc_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
        end
    end

endmodule
